vga_buffer_sched: RTL
=====================

Name: vga_buffer_sched

Overview:
Double-buffer write scheduler for the VGA framebuffer pair (32-word and 64-word line memories). It accepts pixel-word writes from the Nios-side requester through a valid/ready FIFO and drains them into the current back buffer. It executes page-swap requests only at the start of a vsync pulse, and only after all writes issued before the swap have landed. It drives the vgaController write inputs: data, wraddress, wren and memorySel.

Parameters:
DATA_W, 32, write data width
ADDR_W, 6, framebuffer word address width
FIFO_DEPTH, 4, write FIFO entries (power of 2, >=2)
FIFO_AW, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock (same clock as the memories)
rst  in  1  synchronous reset, active-low
vsync  in  1  vertical sync, active-low, synchronous to clk
wr_valid  in  1  write request valid
wr_ready  out  1  FIFO can accept a write
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
swap_req  in  1  request a buffer swap (1-cycle pulse)
swap_pending  out  1  swap accepted, not yet executed
swap_done  out  1  1-cycle pulse when memorySel toggles
fifo_level  out  FIFO_AW+1  current FIFO occupancy
data  out  DATA_W  memory write data
wraddress  out  ADDR_W  memory write address
wren  out  1  memory write enable
memorySel  out  1  back-buffer select (0: memory32 written, 1: memory64 written)

Behaviour:
- Reset (rst==0 at posedge): FIFO empty; state IDLE; wren=0, data=0, wraddress=0, memorySel=0, swap_pending=0, swap_done=0, fifo_level=0; wr_ready=0 while rst low.
- Push: wr_valid&&wr_ready at edge. wr_ready = rst && !full. Push when full is impossible; wr_valid is ignored when wr_ready=0.
- Pop: at most one entry per cycle, allowed in IDLE and DRAIN only. Output regs capture the popped entry with wren=1 the following cycle. Otherwise wren=0 and data/wraddress hold their values.
- Latency: entry pushed at cycle N is popped at N+1 and appears on wren at N+2 (empty FIFO, IDLE). Push and pop in the same cycle leave the level unchanged.
- vsync falling edge: vs_q <= vsync; fall = vs_q && !vsync. vs_q resets to 1.
- FSM:
  - IDLE: pop if non-empty. On swap_req, drain_cnt <= fifo_level minus the pop occurring that cycle. The next state is DRAIN if drain_cnt>0, else WAIT_VS.
  - DRAIN: pop and decrement drain_cnt each cycle. At 0, go to WAIT_VS. Entries pushed at or after the swap_req cycle are not popped. They belong to the new back buffer.
  - WAIT_VS: no pops. On fall, go to SWAP.
  - SWAP (1 cycle): memorySel toggles; swap_done=1; go to IDLE (or CLEAR, see option).
- swap_pending=1 in DRAIN and WAIT_VS.
- swap_req outside IDLE is ignored. It is not queued.
- The last pre-swap wren always precedes the memorySel toggle by >=1 cycle.
- swap_req and wr_valid in the same cycle: that write goes to the post-swap back buffer.
- A fall already in progress when WAIT_VS is entered is honored only if it is detected in a cycle while in WAIT_VS.
- Reset mid-operation: everything returns to reset values. Queued writes and pending swaps are discarded.

Optional Feature:
CLEAR_ON_SWAP_EN. When defined, SWAP goes to CLEAR instead of IDLE. CLEAR writes data=0 to addresses 0..2^ADDR_W-1, one per cycle (wren=1), into the new back buffer, then returns to IDLE. During CLEAR there are no pops, pushes continue, and swap_req is ignored. When undefined, there is no CLEAR state and SWAP always goes to IDLE.

Test Plan:
- Reset, then push (addr=5, data=0xA5A5A5A5) at cycle N -> wren=1, wraddress=5, data=0xA5A5A5A5 at N+2, memorySel=0.
- Hold wr_valid with the drain blocked (in WAIT_VS) -> 4 pushes accepted, wr_ready=0, fifo_level=4; no wren.
- Push 3 words, then swap_req immediately -> 3 wrens with memorySel=0. No toggle until the vsync falling edge, then memorySel=1 and swap_done pulses once.
- swap_req with 2 words queued, then 2 more pushes during WAIT_VS -> the first 2 are written with sel=0 and the last 2 with sel=1 after the swap.
- A second swap_req while swap_pending=1 -> ignored; exactly one toggle occurs.
- With CLEAR_ON_SWAP_EN: swap -> 64 consecutive wren cycles, data=0, addresses 0..63; queued writes drain afterward. Also: reset asserted mid-DRAIN -> all outputs 0, FIFO empty.

Source files
------------

// File: rtl/vga_buffer_sched.sv
// Double-buffer write scheduler: FIFOs pixel writes into the back buffer and swaps buffers on vsync.
// Optional macro CLEAR_ON_SWAP_EN zero-fills the new back buffer after every swap.
module vga_buffer_sched #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vsync,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic              swap_done,
    output logic [FIFO_AW:0]  fifo_level,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] wraddress,
    output logic              wren,
    output logic              memorySel
);

    localparam logic [FIFO_AW:0]   DEPTH_L = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   ONE_L   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   ZERO_L  = '0;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        WAIT_VS = 3'd2,
        SWAP    = 3'd3,
        CLEAR   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0]  fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   drain_cnt;
    logic [FIFO_AW:0]   drain_cnt_nxt;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               vs_q;
    logic               fall;
    logic               sel_toggle;
`ifdef CLEAR_ON_SWAP_EN
    logic [ADDR_W-1:0]  clear_addr;
`endif

    assign full         = (count == DEPTH_L);
    assign empty        = (count == ZERO_L);
    assign wr_ready     = rst && !full;
    assign push         = wr_valid && wr_ready;
    assign fall         = vs_q && !vsync;
    assign fifo_level   = count;
    assign swap_pending = (state == DRAIN) || (state == WAIT_VS);

    // drain_cnt snapshots the entries queued before the swap request; later pushes belong to the next frame
    always_comb begin
        state_nxt     = state;
        pop           = 1'b0;
        drain_cnt_nxt = drain_cnt;
        sel_toggle    = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
                if (swap_req) begin
                    drain_cnt_nxt = count - (empty ? ZERO_L : ONE_L);
                    state_nxt     = (drain_cnt_nxt != ZERO_L) ? DRAIN : WAIT_VS;
                end
            end
            DRAIN: begin
                pop           = !empty;
                drain_cnt_nxt = drain_cnt - ONE_L;
                if (drain_cnt == ONE_L) begin
                    state_nxt = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (fall) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                sel_toggle = 1'b1;
`ifdef CLEAR_ON_SWAP_EN
                state_nxt  = CLEAR;
`else
                state_nxt  = IDLE;
`endif
            end
`ifdef CLEAR_ON_SWAP_EN
            CLEAR: begin
                if (clear_addr == '1) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drain_cnt  <= '0;
            vs_q       <= 1'b1;
            wren       <= 1'b0;
            data       <= '0;
            wraddress  <= '0;
            memorySel  <= 1'b0;
            swap_done  <= 1'b0;
`ifdef CLEAR_ON_SWAP_EN
            clear_addr <= '0;
`endif
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            vs_q      <= vsync;
            swap_done <= sel_toggle;
            if (sel_toggle) begin
                memorySel <= !memorySel;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + ONE_L;
                2'b01:   count <= count - ONE_L;
                default: count <= count;
            endcase
            // memory write stage: one cycle behind the pop decision
            wren <= pop;
            if (pop) begin
                data      <= fifo_data[rd_ptr];
                wraddress <= fifo_addr[rd_ptr];
            end
`ifdef CLEAR_ON_SWAP_EN
            if (state == CLEAR) begin
                wren       <= 1'b1;
                data       <= '0;
                wraddress  <= clear_addr;
                clear_addr <= clear_addr + ADDR_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

endmodule
